// File: rtl/ren_conv_pkg.sv
// Shared types and constants for the convolver result drain.
package ren_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * LANE_W;
    localparam int KEEP_W         = BYTES_PER_WORD;
    localparam int FIFO_W         = WORD_W + KEEP_W + 1;

    // Byte-valid mask for a word whose highest filled lane is last_lane.
    function automatic logic [KEEP_W-1:0] keep_mask(input logic [1:0] last_lane);
        keep_mask = KEEP_W'((1 << (int'(last_lane) + 1)) - 1);
    endfunction

endpackage

// File: rtl/ren_conv_result_drain_if.sv
// Packed-word stream port: valid/ready handshake with data, byte keep and last flag.
interface ren_conv_result_drain_if;
    logic                             m_valid;
    logic                             m_ready;
    logic [ren_conv_pkg::WORD_W-1:0]  m_data;
    logic [ren_conv_pkg::KEEP_W-1:0]  m_keep;
    logic                             m_last;

    modport master (output m_valid, output m_data, output m_keep, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_keep, input m_last, output m_ready);
endinterface

// File: rtl/ren_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; empty output reads as zero.
module ren_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ren_conv_result_drain.sv
// Streams result-RAM bytes out as little-endian 32-bit words with keep/last.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_READ  | issuing RAM reads while bytes remain and a FIFO slot is reservable
//   ST_FLUSH | last read issued; waiting for final byte and FIFO to drain
//   ST_DONE  | one-cycle done pulse
module ren_conv_result_drain import ren_conv_pkg::*; #(
    parameter int RSLT_ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [RSLT_ADDR_WIDTH:0]    count,
    output logic [RSLT_ADDR_WIDTH-1:0]  rd_addr,
    output logic                        rd_en,
    input  logic [LANE_W-1:0]           rd_data,
    ren_conv_result_drain_if.master     m,
    output logic                        busy,
    output logic                        done
);
    localparam logic [RSLT_ADDR_WIDTH:0]      REM_ONE = 1;
    localparam logic [$clog2(FIFO_DEPTH):0]   CNT_ONE = 1;

    drain_state_t                   state, state_nxt;
    logic [RSLT_ADDR_WIDTH-1:0]     addr;
    logic [RSLT_ADDR_WIDTH:0]       remaining;
    logic [1:0]                     issue_lane;
    logic                           rd_vld;
    logic [1:0]                     rd_lane;
    logic                           rd_final;
    logic [3*LANE_W-1:0]            asm_q;
    logic                           word_done;
    logic                           slot_ok;
    logic                           pop;
    logic [FIFO_W-1:0]              push_word;
    logic [FIFO_W-1:0]              pop_word;
    logic [$clog2(FIFO_DEPTH):0]    fifo_cnt;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           m_valid_i;

    // An in-flight byte that closes a word will push next cycle, so its slot is held back.
    assign word_done = rd_vld && ((rd_lane == 2'd3) || rd_final);
    assign slot_ok   = !fifo_full && ((int'(fifo_cnt) + int'(word_done)) < FIFO_DEPTH);
    assign rd_en     = (state == ST_READ) && (remaining != '0) && slot_ok;
    assign rd_addr   = addr;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    assign m_valid_i = !fifo_empty;
    assign pop       = m_valid_i && m.m_ready;
    assign m.m_valid = m_valid_i;
    assign {m.m_last, m.m_keep, m.m_data} = pop_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (count == '0) ? ST_DONE : ST_READ;
            ST_READ:  if (rd_en && (remaining == REM_ONE)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (!rd_vld && (fifo_empty || ((fifo_cnt == CNT_ONE) && pop)))
                          state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr       <= '0;
            remaining  <= '0;
            issue_lane <= '0;
            rd_vld     <= 1'b0;
            rd_lane    <= '0;
            rd_final   <= 1'b0;
            asm_q      <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                addr       <= '0;
                remaining  <= count;
                issue_lane <= '0;
            end else if (rd_en) begin
                remaining  <= remaining - 1'b1;
                if (addr != '1) addr <= addr + 1'b1;
                issue_lane <= issue_lane + 1'b1;
            end
            rd_vld   <= rd_en;
            rd_lane  <= issue_lane;
            rd_final <= rd_en && (remaining == REM_ONE);
            if (rd_vld && !word_done) asm_q[rd_lane*LANE_W +: LANE_W] <= rd_data;
        end
    end

    // Lanes above the landing byte stay zero on a partial word.
    always_comb begin
        push_word = '0;
        for (int i = 0; i < BYTES_PER_WORD-1; i++) begin
            if (i < int'(rd_lane)) push_word[i*LANE_W +: LANE_W] = asm_q[i*LANE_W +: LANE_W];
        end
        push_word[rd_lane*LANE_W +: LANE_W] = rd_data;
        push_word[WORD_W +: KEEP_W]         = keep_mask(rd_lane);
        push_word[FIFO_W-1]                 = rd_final;
    end

    ren_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (word_done),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (pop_word),
        .count     (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_ren_conv_result_drain.sv
// Randomized bench for ren_conv_result_drain against a word-level packing model.
module tb_ren_conv_result_drain;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [6:0]  count;
    logic [5:0]  rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data = 8'h00;
    logic        busy;
    logic        done;

    ren_conv_result_drain_if m_if ();

    ren_conv_result_drain #(.RSLT_ADDR_WIDTH(6), .FIFO_DEPTH(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .count   (count),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .m       (m_if),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] ram [64];
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    int    n_vec = 0;
    int    n_err = 0;
    word_t exp_q[$];
    word_t got_q[$];
    int    done_cnt, rd_cnt, busy_cnt, first_valid, first_rd, last_hs, done_cyc, start_cyc;
    bit    prev_stall;
    word_t prev_word;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t cur_word();
        return {m_if.m_data, m_if.m_keep, m_if.m_last};
    endfunction

    task automatic check_quiet(input string tag);
        chk(tag, {m_if.m_valid, m_if.m_data, m_if.m_keep, m_if.m_last, busy, done, rd_en, rd_addr}, 64'd0);
    endtask

    task automatic drive_ready(input int mode);
        case (mode)
            0:       m_if.m_ready = 1'b1;
            1:       m_if.m_ready = ~m_if.m_ready;
            default: m_if.m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Expected word stream straight from the packing rules.
    task automatic build_expected(input int n);
        word_t w;
        int    nb;
        exp_q.delete();
        for (int wi = 0; wi * 4 < n; wi++) begin
            w  = '0;
            nb = 0;
            for (int b = 0; b < 4; b++) begin
                if (wi * 4 + b < n) begin
                    w.d = w.d | (32'(ram[wi*4+b]) << (8 * b));
                    nb++;
                end
            end
            w.k = 4'((1 << nb) - 1);
            w.l = (wi * 4 + 4 >= n);
            exp_q.push_back(w);
        end
    endtask

    task automatic sample(input int n);
        if (m_if.m_valid && m_if.m_ready) begin
            got_q.push_back(cur_word());
            last_hs = cyc;
        end
        if (m_if.m_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
            chk("hold_valid", m_if.m_valid, 1);
            chk("hold_word", cur_word(), prev_word);
        end
        prev_stall = m_if.m_valid && !m_if.m_ready;
        prev_word  = cur_word();
        if (rd_en) begin
            chk("rd_in_range", rd_cnt < n, 1);
            chk("rd_addr", rd_addr, rd_cnt);
            if (first_rd < 0) first_rd = cyc;
            rd_cnt++;
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic run_drain(input int n, input int rmode, input int ram_mode,
                             input bit busy_restart, input int abort_words, input string tag);
        int post;
        for (int i = 0; i < 64; i++) begin
            case (ram_mode)
                0:       ram[i] = 8'(i + 1);
                1:       ram[i] = 8'(8'hA0 + i);
                default: ram[i] = 8'($urandom);
            endcase
        end
        build_expected(n);
        got_q.delete();
        done_cnt = 0; rd_cnt = 0; busy_cnt = 0;
        first_valid = -1; first_rd = -1; last_hs = -1; done_cyc = -1;
        prev_stall = 1'b0;

        count = 7'(n);
        start = 1'b1;
        m_if.m_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        drive_ready(rmode);
        post = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            sample(n);
            if (abort_words > 0 && got_q.size() >= abort_words) break;
            if (done_cnt > 0) post++;
            if (post >= 4) break;
            @(posedge clk); #1;
            drive_ready(rmode);
            if (busy_restart && c == 1) begin
                start = 1'b1;
                count = 7'd8;
            end else if (busy_restart && c == 2) begin
                start = 1'b0;
            end
        end

        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        if (abort_words == 0) begin
            chk({tag, "_nwords"}, got_q.size(), exp_q.size());
            chk({tag, "_done_cnt"}, done_cnt, 1);
            chk({tag, "_rd_cnt"}, rd_cnt, n);
            chk({tag, "_busy_len"}, busy_cnt, done_cyc - start_cyc + 1);
            if (n > 0) chk({tag, "_done_after_last"}, done_cyc, last_hs + 1);
            else begin
                chk({tag, "_done_at"}, done_cyc, start_cyc);
                chk({tag, "_no_valid"}, first_valid, -1);
            end
            if (rmode == 0 && n >= 4) begin
                chk({tag, "_first_rd"}, first_rd, start_cyc);
                chk({tag, "_first_valid"}, first_valid - start_cyc, 5);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        count = '0;
        m_if.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_outputs");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_drain(8, 0, 0, 1'b0, 0, "c8");
        if (got_q.size() == 2) begin
            chk("c8_lit0", got_q[0], {32'h04030201, 4'hF, 1'b0});
            chk("c8_lit1", got_q[1], {32'h08070605, 4'hF, 1'b1});
        end

        run_drain(6, 0, 1, 1'b0, 0, "c6");
        if (got_q.size() == 2) begin
            chk("c6_lit0", got_q[0], {32'hA3A2A1A0, 4'hF, 1'b0});
            chk("c6_lit1", got_q[1], {32'h0000A5A4, 4'h3, 1'b1});
        end

        run_drain(64, 1, 2, 1'b0, 0, "c64_toggle");
        run_drain(0, 0, 2, 1'b0, 0, "c0");
        run_drain(4, 0, 0, 1'b1, 0, "busy_restart");

        run_drain(32, 0, 2, 1'b0, 2, "abort");
        reset_n = 1'b0;
        #1;
        check_quiet("mid_reset_outputs");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_drain(4, 0, 0, 1'b0, 0, "after_reset");

        run_drain(1, 0, 2, 1'b0, 0, "c1");
        run_drain(5, 2, 2, 1'b0, 0, "c5_rand");
        for (int t = 0; t < 12; t++)
            run_drain($urandom_range(0, 64), 2, 2, 1'b0, 0, $sformatf("rand%0d", t));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
